// File: rtl/conv_pkg.sv
// Shared definitions for the convolution tap MAC: FSM encoding and a
// constant-evaluable clog2 used to size counters.
package conv_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    DONE  = ST_DONE
  } convState;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/conv_mac_acc.sv
// Registered signed multiply-accumulate: unsigned tap times signed coefficient,
// sign-extended into the accumulator. accNext exposes the value the next edge loads.
module conv_mac_acc #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2*WIDTH+4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic        [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] accNext
);

  logic signed [2*WIDTH:0] prod;

  // Zero-extend the tap so the product is a true signed*unsigned result.
  assign prod = $signed({1'b0, a}) * b;

  always_comb begin
    accNext = acc;
    if (clr)
      accNext = '0;
    else if (en)
      accNext = acc + ACC_W'(prod);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      acc <= '0;
    else
      acc <= accNext;
  end

endmodule

// File: rtl/conv_tap_mac.sv
// Reads DEPTH taps from the tap register file one at a time, multiplies each by
// its latched coefficient and emits the sum with a one-cycle result_valid pulse.
module conv_tap_mac
  import conv_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 5,
  parameter int ADDR    = 3,
  parameter int ACC_W   = 2*WIDTH+4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DEPTH*WIDTH-1:0]  coeff,
  output logic                    rd_en,
  output logic [ADDR-1:0]         rd_addr,
  input  logic [WIDTH-1:0]        rd_data,
  input  logic                    rd_data_valid,
  output logic signed [ACC_W-1:0] result,
  output logic                    result_valid,
  output logic                    busy,
  output logic                    error,
  output logic [1:0]              dbgState
);

  localparam int IDX_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int CNT_W = clog2(TIMEOUT + 1);

  // Read handshake: rd_en pulses for one cycle with rd_addr; the file answers
  // later with a one-cycle rd_data_valid. Only one read is ever outstanding and
  // rd_data_valid is only consumed in WAIT.
  convState                  state;
  logic [IDX_W-1:0]          tapIdx;
  logic [CNT_W-1:0]          waitCnt;
  logic signed [WIDTH-1:0]   coefReg [DEPTH];
  logic                      accClr;
  logic                      accEn;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   accNext;

  assign accClr   = (state == IDLE) && start;
  assign accEn    = (state == WAIT) && rd_data_valid;
  assign busy     = (state != IDLE);
  assign dbgState = state;

  always_ff @(posedge clk) begin
    if (accClr) begin
      for (int i = 0; i < DEPTH; i++)
        coefReg[i] <= coeff[i*WIDTH +: WIDTH];
    end
  end

  conv_mac_acc #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (accClr),
    .en      (accEn),
    .a       (rd_data),
    .b       (coefReg[tapIdx]),
    .acc     (acc),
    .accNext (accNext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      tapIdx       <= '0;
      waitCnt      <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ISSUE;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            tapIdx  <= '0;
            waitCnt <= '0;
            error   <= 1'b0;
          end
        end
        ISSUE: begin
          rd_en   <= 1'b0;
          waitCnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (rd_data_valid) begin
            // The last product is folded in via accNext so result lines up with result_valid.
            if (tapIdx == IDX_W'(DEPTH - 1)) begin
              result       <= accNext;
              result_valid <= 1'b1;
              state        <= DONE;
            end else begin
              tapIdx  <= tapIdx + IDX_W'(1);
              rd_addr <= ADDR'(tapIdx + IDX_W'(1));
              rd_en   <= 1'b1;
              state   <= ISSUE;
            end
          end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
            error <= 1'b1;
            state <= IDLE;
          end else begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_tap_mac.sv
// Bench for conv_tap_mac: models the tap register file (fixed or random valid
// latency, optional dead address) and scoreboards every result_valid pulse.
module tb_conv_tap_mac;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int ADDR  = 3;
  localparam int ACC_W = 2*WIDTH+4;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic [DEPTH*WIDTH-1:0]  coeff;
  logic                    rd_en;
  logic [ADDR-1:0]         rd_addr;
  logic [WIDTH-1:0]        rd_data;
  logic                    rd_data_valid;
  logic signed [ACC_W-1:0] result;
  logic                    result_valid;
  logic                    busy;
  logic                    error;
  logic [1:0]              dbgState;

  logic                    rfValid;
  logic [WIDTH-1:0]        rfData;
  logic                    spurValid;
  logic [WIDTH-1:0]        spurData;
  int                      blockAddr;
  bit                      randDelay;

  logic [WIDTH-1:0]        tapVals [DEPTH];
  logic signed [WIDTH-1:0] coefVals [DEPTH];
  logic [ACC_W-1:0]        exp_q [$];
  logic [ACC_W-1:0]        lastExp;

  int total;
  int bad;

  assign rd_data_valid = rfValid | spurValid;
  assign rd_data       = rfValid ? rfData : spurData;

  conv_tap_mac dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .coeff         (coeff),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .result        (result),
    .result_valid  (result_valid),
    .busy          (busy),
    .error         (error),
    .dbgState      (dbgState)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- register file model ----------------
  always begin
    logic [ADDR-1:0] a;
    int d;
    @(posedge clk);
    if (rst && rd_en) begin
      total++;
      if (rd_addr > ADDR'(DEPTH - 1)) begin
        bad++;
        $display("FAIL rd_addr_range got=%0d max=%0d", rd_addr, DEPTH - 1);
      end
      a = rd_addr;
      d = randDelay ? $urandom_range(1, 4) : 1;
      if (int'(a) != blockAddr) begin
        repeat (d - 1) @(posedge clk);
        #1;
        rfValid = 1'b1;
        rfData  = tapVals[a];
        @(posedge clk);
        #1;
        rfValid = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [ACC_W-1:0] e;
    if (rst && result_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result_valid got=%0d", result);
      end else begin
        e = exp_q.pop_front();
        if (result !== e) begin
          bad++;
          $display("FAIL result got=%0d exp=%0d", result, $signed(e));
        end
      end
    end
  end

  // ---------------- helpers / drivers ----------------
  function automatic logic [DEPTH*WIDTH-1:0] packCoeff();
    logic [DEPTH*WIDTH-1:0] c;
    for (int i = 0; i < DEPTH; i++) c[i*WIDTH +: WIDTH] = coefVals[i];
    return c;
  endfunction

  function automatic logic [ACC_W-1:0] modelSum();
    int s;
    s = 0;
    for (int i = 0; i < DEPTH; i++) s += int'(tapVals[i]) * int'(coefVals[i]);
    return ACC_W'(s);
  endfunction

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL busy_timeout got=%0b exp=0", busy);
    end
  endtask

  task automatic doRun(input logic [ACC_W-1:0] expVal);
    coeff = packCoeff();
    exp_q.push_back(expVal);
    lastExp = expVal;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL error_cleared_on_start got=%0b exp=0", error);
    end
    waitIdle();
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL error_after_run got=%0b exp=0", error);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    #1;
    total++;
    if ({rd_en, rd_addr, result, result_valid, busy, error, dbgState} !== '0) begin
      bad++;
      $display("FAIL reset_state got=%0h exp=0",
               {rd_en, rd_addr, result, result_valid, busy, error, dbgState});
    end
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [5:0] gotV;
    logic [5:0] expV;
    bit         en;
    for (int i = 0; i < DEPTH; i++) begin
      tapVals[i]  = WIDTH'((i + 1) * 10);
      coefVals[i] = 8'sd1;
    end
    coeff = packCoeff();
    exp_q.push_back(ACC_W'(150));
    lastExp = ACC_W'(150);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      en   = (c % 2 == 1) && (c <= 9);
      gotV = {rd_en, en ? rd_addr : 3'd0, result_valid, busy};
      expV = {en, en ? 3'((c - 1) / 2) : 3'd0, c == 11, c <= 11};
      total++;
      if (gotV !== expV) begin
        bad++;
        $display("FAIL basic_cycle%0d {rd_en,addr,rv,busy} got=%b exp=%b", c, gotV, expV);
      end
    end
  endtask

  task automatic test_values();
    for (int i = 0; i < DEPTH; i++) begin
      tapVals[i]  = 8'd255;
      coefVals[i] = -8'sd128;
    end
    doRun(-ACC_W'(163200));
    coefVals[0] = 8'sd1;
    coefVals[1] = -8'sd1;
    coefVals[2] = 8'sd2;
    coefVals[3] = -8'sd2;
    coefVals[4] = 8'sd3;
    for (int i = 0; i < DEPTH; i++) tapVals[i] = 8'd5;
    doRun(ACC_W'(15));
  endtask

  task automatic test_timeout();
    logic [3:0] gotV;
    logic [3:0] expV;
    blockAddr = 2;
    for (int i = 0; i < DEPTH; i++) begin
      tapVals[i]  = 8'd7;
      coefVals[i] = 8'sd3;
    end
    coeff = packCoeff();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      gotV = {rd_en, result_valid, busy, error};
      expV = {(c == 1) || (c == 3) || (c == 5), 1'b0, c <= 20, c >= 21};
      total++;
      if (gotV !== expV) begin
        bad++;
        $display("FAIL timeout_cycle%0d {rd_en,rv,busy,err} got=%b exp=%b", c, gotV, expV);
      end
    end
    total++;
    if (result !== lastExp) begin
      bad++;
      $display("FAIL timeout_result_kept got=%0d exp=%0d", result, $signed(lastExp));
    end
    blockAddr = -1;
    doRun(ACC_W'(105));
  endtask

  task automatic test_reset_mid();
    blockAddr = 3;
    for (int i = 0; i < DEPTH; i++) begin
      tapVals[i]  = WIDTH'(i * 20 + 3);
      coefVals[i] = -8'sd7;
    end
    coeff = packCoeff();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if ({busy, dbgState} !== {1'b1, 2'd2}) begin
      bad++;
      $display("FAIL midrun_in_wait got=%b exp=110", {busy, dbgState});
    end
    rst = 1'b0;
    #1;
    total++;
    if ({rd_en, rd_addr, result, result_valid, busy, error, dbgState} !== '0) begin
      bad++;
      $display("FAIL async_reset_outputs got=%0h exp=0",
               {rd_en, rd_addr, result, result_valid, busy, error, dbgState});
    end
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    blockAddr = -1;
    for (int i = 0; i < DEPTH; i++) coefVals[i] = 8'sd9;
    doRun(modelSum());
  endtask

  task automatic test_back_to_back();
    logic [1:0] gotV;
    logic [1:0] expV;
    for (int i = 0; i < DEPTH; i++) begin
      tapVals[i]  = WIDTH'(200 - i * 30);
      coefVals[i] = WIDTH'(i * 25 - 60);
    end
    coeff = packCoeff();
    exp_q.push_back(modelSum());
    exp_q.push_back(modelSum());
    lastExp = modelSum();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 24) start = 1'b0;
      gotV = {result_valid, busy};
      expV = {(c == 11) || (c == 23), !((c == 12) || (c == 24))};
      total++;
      if (gotV !== expV) begin
        bad++;
        $display("FAIL held_start_cycle%0d {rv,busy} got=%b exp=%b", c, gotV, expV);
      end
    end
    // Spurious valids outside WAIT and start pulses while busy must not disturb the sum.
    for (int i = 0; i < DEPTH; i++) begin
      tapVals[i]  = WIDTH'($urandom_range(0, 255));
      coefVals[i] = WIDTH'($urandom_range(0, 255));
    end
    coeff = packCoeff();
    exp_q.push_back(modelSum());
    lastExp = modelSum();
    @(negedge clk);
    start     = 1'b1;
    spurValid = 1'b1;
    spurData  = WIDTH'($urandom_range(1, 255));
    @(posedge clk);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      start     = (c == 4) || (c == 11);
      spurValid = (c % 2 == 1) && (c <= 11);
      spurData  = WIDTH'($urandom_range(1, 255));
      if (c >= 12) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL no_restart_cycle%0d busy got=%b exp=0", c, busy);
        end
      end
    end
    start     = 1'b0;
    spurValid = 1'b0;
  endtask

  task automatic test_random();
    randDelay = 1'b1;
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        tapVals[i]  = WIDTH'($urandom_range(0, 255));
        coefVals[i] = WIDTH'($urandom_range(0, 255));
      end
      doRun(modelSum());
    end
    randDelay = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    start     = 1'b0;
    coeff     = '0;
    rfValid   = 1'b0;
    rfData    = '0;
    spurValid = 1'b0;
    spurData  = '0;
    blockAddr = -1;
    randDelay = 1'b0;
    lastExp   = '0;

    test_reset();
    test_basic();
    test_values();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();

    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_results got=%0d pending exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
